// File: rtl/dbus_responder_pkg.sv
// Shared data-bus types and the responder state encoding, reused by the
// dbus responder and later ibus/cache responders.
package dbus_responder_pkg;

    localparam int unsigned DBUS_ADDR_W = 64;
    localparam int unsigned DBUS_DATA_W = 64;
    localparam int unsigned DBUS_STRB_W = DBUS_DATA_W / 8;

    typedef struct packed {
        logic                   valid;
        logic [DBUS_ADDR_W-1:0] addr;
        logic [1:0]             size;
        logic [DBUS_STRB_W-1:0] strobe;
        logic [DBUS_DATA_W-1:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic                   addr_ok;
        logic                   data_ok;
        logic [DBUS_DATA_W-1:0] data;
    } dbus_resp_t;

    typedef enum logic [1:0] {DR_IDLE, DR_WAIT, DR_RESP} dresp_state_t;

    // Merge the strobed bytes of wdata over old.
    function automatic logic [DBUS_DATA_W-1:0] strobe_merge(
        input logic [DBUS_DATA_W-1:0] old,
        input logic [DBUS_DATA_W-1:0] wdata,
        input logic [DBUS_STRB_W-1:0] strobe
    );
        logic [DBUS_DATA_W-1:0] res;
        res = old;
        for (int b = 0; b < DBUS_STRB_W; b++) begin
            if (strobe[b]) begin
                res[b*8 +: 8] = wdata[b*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dbus_responder_byte_strobe_ram.sv
// Word store with per-byte write enables, one shared address port and
// asynchronous read; contents are never reset.
module byte_strobe_ram
    import dbus_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    localparam int unsigned AW = $clog2(DEPTH_WORDS)
) (
    input  logic                   clk,
    input  logic [DBUS_STRB_W-1:0] we_i,
    input  logic [AW-1:0]          addr_i,
    input  logic [DBUS_DATA_W-1:0] wdata_i,
    output logic [DBUS_DATA_W-1:0] rdata_o
);

    logic [DBUS_DATA_W-1:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        mem_q[addr_i] <= strobe_merge(mem_q[addr_i], wdata_i, we_i);
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dbus_responder.sv
// Data-bus responder: latches a request, answers after LATENCY cycles from
// a byte-strobed word store, flags out-of-range accesses and protocol violations.
module dbus_responder
    import dbus_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2,
    parameter logic [63:0] BASE_ADDR   = 64'h8000_0000
) (
    input  logic       clk,
    input  logic       reset,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp,
    output logic       oob,
    output logic       viol
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W = $clog2(LATENCY + 1);
    localparam logic [63:0] SPAN  = 64'(DEPTH_WORDS) << 3;

    dresp_state_t           state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   viol_q, viol_d;
    logic                   accept;

    logic [DBUS_ADDR_W-1:0] addr_q;
    logic [DBUS_STRB_W-1:0] strobe_q;
    logic [DBUS_DATA_W-1:0] data_q;

    logic [63:0]            offset;
    logic                   in_range;
    logic [IDX_W-1:0]       idx;
    logic                   changed;
    logic                   resp_active;
    logic [DBUS_STRB_W-1:0] we;
    logic [DBUS_DATA_W-1:0] rdata;
    logic                   unused_size;

    // size has no addressing meaning: the whole aligned word is always used
    assign unused_size = ^dreq.size;

    // Subtracting first keeps the upper bound free of 64-bit wrap-around
    assign offset   = addr_q - BASE_ADDR;
    assign in_range = (addr_q >= BASE_ADDR) && (offset < SPAN);
    assign idx      = offset[3 +: IDX_W];

    assign changed = (dreq.addr != addr_q) || (dreq.strobe != strobe_q) ||
                     (dreq.data != data_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        viol_d  = viol_q;
        accept  = 1'b0;
        case (state_q)
            DR_IDLE: begin
                if (dreq.valid) begin
                    accept  = 1'b1;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = (LATENCY == 1) ? DR_RESP : DR_WAIT;
                end
            end
            DR_WAIT: begin
                if (!dreq.valid) begin
                    viol_d  = 1'b1;
                    state_d = DR_IDLE;
                end else begin
                    if (changed) begin
                        viol_d = 1'b1;
                    end
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = DR_RESP;
                    end
                end
            end
            DR_RESP: begin
                if (dreq.valid && changed) begin
                    viol_d = 1'b1;
                end
                state_d = DR_IDLE;
            end
            default: state_d = DR_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= DR_IDLE;
            cnt_q   <= '0;
            viol_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            viol_q  <= viol_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q   <= dreq.addr;
            strobe_q <= dreq.strobe;
            data_q   <= dreq.data;
        end
    end

    // Reset in the response cycle suppresses both the response and the write
    assign resp_active = reset && (state_q == DR_RESP);
    assign we          = (resp_active && in_range) ? strobe_q : '0;

    byte_strobe_ram #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_ram (
        .clk     (clk),
        .we_i    (we),
        .addr_i  (idx),
        .wdata_i (data_q),
        .rdata_o (rdata)
    );

    always_comb begin
        dresp         = '0;
        dresp.addr_ok = resp_active;
        dresp.data_ok = resp_active;
        dresp.data    = (resp_active && in_range) ? rdata : '0;
    end

    assign oob  = resp_active && !in_range;
    assign viol = viol_q;

endmodule
